// File: rtl/lsu_dccm_mem.sv
// ---------------------------------------------------------------------------
// lsu_dccm_mem
//
// Purpose:
//   Responder end of the LSU DCCM port. The array is built from
//   DCCM_NUM_BANKS word-interleaved single-port banks. Each word holds
//   39 bits, laid out as {ecc[6:0], data[31:0]}.
//
//   After reset, an init sweep writes zero to every index of every bank.
//   All-zero is a valid ECC codeword. The sweep takes one index per cycle,
//   so it lasts 2^INDEX_BITS cycles. Until it completes, dccm_ready stays
//   low and LSU accesses are ignored.
//
//   Reads fetch both the lo and hi addresses at the same clock edge. The
//   registered results appear on the following cycle.
//
// Ports:
//   clk               in   1     core clock
//   rst_l             in   1     async active-low reset
//   dccm_wren         in   1     write strobe
//   dccm_rden         in   1     read strobe (lo and hi ports)
//   dccm_wr_addr      in   16    write byte address
//   dccm_rd_addr_lo   in   16    read byte address, lo port
//   dccm_rd_addr_hi   in   16    read byte address, hi port (end address)
//   dccm_wr_data      in   39    {ecc, data} to write
//   dccm_err_inj_en   in   1     (RV_DCCM_ERR_INJ_EN only) corrupt writes
//   dccm_err_inj_bit  in   6     (RV_DCCM_ERR_INJ_EN only) bit to flip
//   dccm_rd_data_lo   out  39    read data, lo port
//   dccm_rd_data_hi   out  39    read data, hi port
//   dccm_ready        out  1     init sweep complete
//   dccm_conflict     out  1     sticky illegal bank collision flag
//
// Optional feature:
//   Define RV_DCCM_ERR_INJ_EN to add the error-injection inputs.
//   While dccm_err_inj_en is high, each READY write stores wr_data with
//   bit dccm_err_inj_bit flipped. A bit number of 39 or above flips
//   nothing. Init sweep writes are never corrupted.
// ---------------------------------------------------------------------------
module lsu_dccm_mem #(
    parameter int DCCM_BITS        = 16,
    parameter int DCCM_NUM_BANKS   = 8,
    parameter int DCCM_DATA_WIDTH  = 32,
    parameter int DCCM_FDATA_WIDTH = 39
) (
    input  logic                        clk,
    input  logic                        rst_l,
    input  logic                        dccm_wren,
    input  logic                        dccm_rden,
    input  logic [DCCM_BITS-1:0]        dccm_wr_addr,
    input  logic [DCCM_BITS-1:0]        dccm_rd_addr_lo,
    input  logic [DCCM_BITS-1:0]        dccm_rd_addr_hi,
    input  logic [DCCM_FDATA_WIDTH-1:0] dccm_wr_data,
`ifdef RV_DCCM_ERR_INJ_EN
    input  logic                        dccm_err_inj_en,
    input  logic [5:0]                  dccm_err_inj_bit,
`endif
    output logic [DCCM_FDATA_WIDTH-1:0] dccm_rd_data_lo,
    output logic [DCCM_FDATA_WIDTH-1:0] dccm_rd_data_hi,
    output logic                        dccm_ready,
    output logic                        dccm_conflict
);

    localparam int BANK_BITS  = $clog2(DCCM_NUM_BANKS);
    localparam int INDEX_BITS = DCCM_BITS - 2 - BANK_BITS;
    localparam int DEPTH      = 1 << INDEX_BITS;

    typedef enum logic {
        ST_INIT,
        ST_READY
    } state_t;

    state_t                      state;
    logic [INDEX_BITS-1:0]       init_idx;
    logic [DCCM_FDATA_WIDTH-1:0] mem [DCCM_NUM_BANKS][DEPTH];

    logic [BANK_BITS-1:0]        wr_bank, lo_bank, hi_bank;
    logic [INDEX_BITS-1:0]       wr_index, lo_index, hi_index;
    logic [DCCM_FDATA_WIDTH-1:0] wr_data_eff;
    logic                        lohi_clash, wr_rd_clash;

    // Byte offset bits and the data/ECC split are not needed to address a
    // word; they are collected here only so they are visibly consumed.
    logic       unused_addr_bits;
    logic [31:0] unused_cfg;
    assign unused_addr_bits = ^{dccm_wr_addr[1:0], dccm_rd_addr_lo[1:0],
                                dccm_rd_addr_hi[1:0]};
    assign unused_cfg       = 32'(DCCM_DATA_WIDTH);

    // Word-interleaved address split: the low word bits select the bank,
    // and the remaining upper bits select the row within that bank.
    assign wr_bank  = dccm_wr_addr[2 +: BANK_BITS];
    assign lo_bank  = dccm_rd_addr_lo[2 +: BANK_BITS];
    assign hi_bank  = dccm_rd_addr_hi[2 +: BANK_BITS];
    assign wr_index = dccm_wr_addr[DCCM_BITS-1 : 2+BANK_BITS];
    assign lo_index = dccm_rd_addr_lo[DCCM_BITS-1 : 2+BANK_BITS];
    assign hi_index = dccm_rd_addr_hi[DCCM_BITS-1 : 2+BANK_BITS];

    // Two kinds of illegal same-cycle collision.
    // (1) lo and hi land on different rows of one single-port bank. The
    //     bank can only serve the lo row, so hi receives the lo-row word.
    // (2) A write shares a bank with either read port. The read still
    //     returns the old word, and the write still lands.
    assign lohi_clash  = (lo_bank == hi_bank) && (lo_index != hi_index);
    assign wr_rd_clash = dccm_wren && ((wr_bank == lo_bank) || (wr_bank == hi_bank));

`ifdef RV_DCCM_ERR_INJ_EN
    // Error injection: flip one selected bit of the write data. A bit
    // number past the word width leaves the data untouched.
    always_comb begin
        wr_data_eff = dccm_wr_data;
        if (dccm_err_inj_en && (dccm_err_inj_bit < 6'(DCCM_FDATA_WIDTH))) begin
            wr_data_eff = dccm_wr_data ^ (DCCM_FDATA_WIDTH'(1) << dccm_err_inj_bit);
        end
    end
`else
    assign wr_data_eff = dccm_wr_data;
`endif

    // Bank storage. This block has no reset. During INIT, one row of every
    // bank is cleared per cycle. In READY, only the LSU write port writes.
    always_ff @(posedge clk) begin
        if (state == ST_INIT) begin
            for (int b = 0; b < DCCM_NUM_BANKS; b++) begin
                mem[b][init_idx] <= '0;
            end
        end else if (dccm_wren) begin
            mem[wr_bank][wr_index] <= wr_data_eff;
        end
    end

    // Control FSM and registered outputs.
    // In INIT, the sweep counter runs and LSU strobes are ignored. The last
    // sweep index moves the FSM to READY and raises dccm_ready together.
    // In READY, rden loads both read registers; otherwise they hold.
    // Reads use the array value from before this edge's write, which gives
    // the required old-data result on a same-bank read/write.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state           <= ST_INIT;
            init_idx        <= '0;
            dccm_ready      <= 1'b0;
            dccm_conflict   <= 1'b0;
            dccm_rd_data_lo <= '0;
            dccm_rd_data_hi <= '0;
        end else begin
            case (state)
                ST_INIT: begin
                    init_idx <= init_idx + INDEX_BITS'(1);
                    if (init_idx == '1) begin
                        state      <= ST_READY;
                        dccm_ready <= 1'b1;
                    end
                end
                ST_READY: begin
                    if (dccm_rden) begin
                        dccm_rd_data_lo <= mem[lo_bank][lo_index];
                        dccm_rd_data_hi <= (lo_bank == hi_bank) ? mem[lo_bank][lo_index]
                                                                : mem[hi_bank][hi_index];
                        if (lohi_clash || wr_rd_clash) begin
                            dccm_conflict <= 1'b1;
                        end
                    end
                end
                default: state <= ST_INIT;
            endcase
        end
    end

endmodule
